led_bank_ctrl: RTL
==================

Name: led_bank_ctrl

Overview:
Parametrised memory-mapped LED output peripheral for the CPU IO bus. It holds an LED_W-bit pattern that the CPU writes in DATA_W-bit chunks. It adds a per-LED blink mask, a programmable blink prescaler, a control register and register readback. It sits behind the IO decoder, which asserts LEDCtrl for this block's address window.

Parameters:
LED_W, 24, number of LED outputs (1..64)
DATA_W, 16, bus data width; chunk size for data and mask registers (8..32)
ADDR_W, 3, register index width; must satisfy 2^ADDR_W >= 2*K+2, where K = ceil(LED_W/DATA_W)
DIV_RST, 16'd49999, reset value of the blink divider register (lower DATA_W bits used)

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
LEDCtrl  input  1  chip select from the IO decoder
ioWrite  input  1  write strobe; acts only with LEDCtrl=1
ioRead  input  1  read strobe; acts only with LEDCtrl=1
ledAddr  input  ADDR_W  register index
write_data  input  DATA_W  write data
submit  input  1  0 = clear/hold-off of pattern and mask (active-low)
read_data  output  DATA_W  readback data
leds  output  LED_W  registered LED drive
blink_phase  output  1  current blink phase, for debug and verification

Behaviour:
- Register map, with K = ceil(LED_W/DATA_W); defaults give K=2:
  - idx 0..K-1: DATA chunk k = pattern[k*DATA_W +: DATA_W]. Bits at or above LED_W are dropped on write and read as 0.
  - idx K..2K-1: MASK chunk (k-K), same packing. A mask bit of 1 makes that LED blink.
  - idx 2K: CTRL. bit0 = OE (output enable), bit1 = BE (blink enable). Other bits read 0.
  - idx 2K+1: DIV, DATA_W bits, the blink half-period in clocks minus 1.
  - All other indices: writes ignored, reads return 0.
- Write: when LEDCtrl=1 and ioWrite=1 at a rising edge, the addressed register is updated at that edge.
- Read: read_data is combinational. It equals the addressed register when LEDCtrl=1 and ioRead=1, otherwise 0. A read and a write to the same index in the same cycle returns the pre-write value.
- reset=0, asynchronous, sets:
  - pattern=0, mask=0, CTRL=2'b01 (OE=1, BE=0), DIV=DIV_RST
  - prescaler=0, blink_phase=0, leds=0
- submit=0, synchronous, every cycle it is held:
  - pattern and mask are cleared to 0; writes to DATA and MASK are ignored.
  - CTRL and DIV writes are still accepted.
  - submit takes priority over a coincident DATA or MASK write.
- Prescaler, a DATA_W-bit counter:
  - When BE=0: counter held at 0 and blink_phase held at 0.
  - When BE=1: if counter==DIV, the counter wraps to 0 and blink_phase toggles; otherwise the counter increments by 1.
  - DIV=0 therefore toggles the phase every cycle. The blink period is 2*(DIV+1) clocks.
- A write to DIV or CTRL clears the counter to 0 and blink_phase to 0 at that edge. This takes priority over a coincident wrap.
- Output register, updated every edge:
  - leds <= OE ? (pattern & ~(mask & {LED_W{blink_phase_next}})) : 0
  - blink_phase_next is the phase value being registered at the same edge.
  - Latency: a DATA write at edge n is visible on leds at edge n+1, i.e. 1 cycle.
- Counter wrap and a DATA write in the same cycle: both take effect, and leds at the next edge reflect the new pattern with the new phase.

Test Plan:
1. Reset then write: reset=0 for 3 cycles, then release; expect leds=0 and read idx4 = 16'h0001. Write idx0=16'hBEEF and idx1=16'h00A5 with submit=1; expect leds=24'hA5BEEF one cycle later. Reading idx1 returns 16'h00A5.
2. Submit clear: with leds=24'hA5BEEF, drive submit=0 for 1 cycle; expect pattern cleared and leds=0 by the following cycle. A DATA write with submit=0 is ignored; a CTRL write of 16'h0003 is accepted.
3. Blink: pattern=24'hFFFFFF, mask=24'h00000F, DIV=3, CTRL=3. Expect blink_phase to toggle every 4 clocks and leds to alternate between 24'hFFFFFF and 24'hFFFFF0 with an 8-clock period.
4. DIV write mid-count: with the counter at 2, write DIV=0. Expect the counter and phase to clear at that edge, then the phase to toggle every cycle after it.
5. OE off / bad address: write CTRL=16'h0002; expect leds=0 while blink_phase keeps running. Write idx7=16'h1234; expect no register change and a read of idx7 to return 0.
6. Async reset mid-blink: drive reset low between clock edges; expect leds, blink_phase and the counter to go to 0 immediately, and DIV to read back DIV_RST after release.

Source files
------------

// File: rtl/led_bank_ctrl.sv
// Memory-mapped LED bank: chunked pattern/mask registers, control, blink prescaler
// and combinational register readback for the CPU IO bus.
module led_bank_ctrl #(
  parameter int          LED_W   = 24,
  parameter int          DATA_W  = 16,
  parameter int          ADDR_W  = 3,
  parameter logic [31:0] DIV_RST = 32'd49999
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              LEDCtrl,
  input  logic              ioWrite,
  input  logic              ioRead,
  input  logic [ADDR_W-1:0] ledAddr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              submit,
  output logic [DATA_W-1:0] read_data,
  output logic [LED_W-1:0]  leds,
  output logic              blink_phase
);

  localparam int                K        = (LED_W + DATA_W - 1) / DATA_W;
  localparam logic [ADDR_W-1:0] CTRL_IDX = ADDR_W'(2 * K);
  localparam logic [ADDR_W-1:0] DIV_IDX  = ADDR_W'(2 * K + 1);
  localparam logic [DATA_W-1:0] DIV_INIT = DIV_RST[DATA_W-1:0];

  logic [LED_W-1:0]  pattern_q, pattern_d;
  logic [LED_W-1:0]  mask_q, mask_d;
  logic              oe_q, oe_d;
  logic              be_q, be_d;
  logic [DATA_W-1:0] div_q, div_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [LED_W-1:0]  leds_q, leds_d;

  logic wr_en, ctrl_wr, div_wr;

  // NOTE: every signal written in an always_comb gets a default on entry, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_en     = LEDCtrl & ioWrite;
    ctrl_wr   = wr_en && (ledAddr == CTRL_IDX);
    div_wr    = wr_en && (ledAddr == DIV_IDX);
    pattern_d = pattern_q;
    mask_d    = mask_q;
    oe_d      = oe_q;
    be_d      = be_q;
    div_d     = div_q;

    // Each LED bit belongs to chunk i/DATA_W; bits past LED_W simply have no flop.
    for (int i = 0; i < LED_W; i++) begin
      if (wr_en && ledAddr == ADDR_W'(i / DATA_W))
        pattern_d[i] = write_data[i % DATA_W];
      if (wr_en && ledAddr == ADDR_W'(K + i / DATA_W))
        mask_d[i] = write_data[i % DATA_W];
    end
    if (!submit) begin
      pattern_d = '0;
      mask_d    = '0;
    end

    if (ctrl_wr) begin
      oe_d = write_data[0];
      be_d = write_data[1];
    end
    if (div_wr) div_d = write_data;
  end

  // Prescaler: a CTRL/DIV write restarts the blink cycle and beats a coincident wrap.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (ctrl_wr || div_wr || !be_q) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + DATA_W'(1);
    end
  end

  always_comb begin
    leds_d = oe_q ? (pattern_q & ~(mask_q & {LED_W{phase_d}})) : '0;
  end

  always_comb begin
    read_data = '0;
    if (LEDCtrl && ioRead) begin
      for (int i = 0; i < LED_W; i++) begin
        if (ledAddr == ADDR_W'(i / DATA_W))     read_data[i % DATA_W] = pattern_q[i];
        if (ledAddr == ADDR_W'(K + i / DATA_W)) read_data[i % DATA_W] = mask_q[i];
      end
      if (ledAddr == CTRL_IDX) read_data = DATA_W'({be_q, oe_q});
      if (ledAddr == DIV_IDX)  read_data = div_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pattern_q <= '0;
      mask_q    <= '0;
      oe_q      <= 1'b1;
      be_q      <= 1'b0;
      div_q     <= DIV_INIT;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      leds_q    <= '0;
    end else begin
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      oe_q      <= oe_d;
      be_q      <= be_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      leds_q    <= leds_d;
    end
  end

  assign leds        = leds_q;
  assign blink_phase = phase_q;

endmodule
